// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and stall counter
module pipe_stage_skid #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 32,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t            state;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    assign out_valid = state != EMPTY;
    assign in_ready  = state != TWO;
    assign occupancy = state == TWO ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
    assign in_fire   = in_valid & in_ready;
    // main/skid register FSM; flush wins over every handshake, emptying zeroes control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_ctrl  <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            out_ctrl <= '0;
            if (CLEAR_DATA != 0) out_data <= '0;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state    <= ONE;
                    out_ctrl <= in_ctrl;
                    out_data <= in_data;
                end
                ONE: if (in_fire && out_ready) begin
                    out_ctrl <= in_ctrl;
                    out_data <= in_data;
                end else if (in_fire) begin
                    state     <= TWO;
                    skid_ctrl <= in_ctrl;
                    skid_data <= in_data;
                end else if (out_ready) begin
                    state    <= EMPTY;
                    out_ctrl <= '0;
                    if (CLEAR_DATA != 0) out_data <= '0;
                end
                TWO: if (out_ready) begin
                    state    <= ONE;
                    out_ctrl <= skid_ctrl;
                    out_data <= skid_data;
                end
                default: state <= EMPTY;
            endcase
        end
    end
    // saturating count of cycles the downstream stalls a valid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: queue-model check of two stage configurations driven by the same stimulus
module tb_pipe_stage_skid;
    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [7:0]  in_ctrl = 0;
    logic [31:0] in_data = 0;
    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [7:0]  a_out_ctrl, b_out_ctrl;
    logic [31:0] a_out_data, b_out_data;
    logic [1:0]  a_occ, b_occ;
    logic [15:0] a_stall;
    logic [3:0]  b_stall;

    pipe_stage_skid u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_stall)
    );
    pipe_stage_skid #(.CLEAR_DATA(0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] c; logic [31:0] d; } ent_t;
    ent_t        q[$];
    int unsigned scnt;
    logic [31:0] held;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        scnt = 0;
        held = 0;
    endtask

    // advance the queue model by one clock using the inputs present at the edge
    task automatic model_clk();
        bit of, inf;
        if (rst) begin
            model_reset();
            return;
        end
        if (q.size() != 0 && !out_ready) scnt++;
        of  = q.size() != 0 && out_ready;
        inf = in_valid && q.size() < 2;
        if (flush) q.delete();
        else begin
            if (of) void'(q.pop_front());
            if (inf) q.push_back({in_ctrl, in_data});
        end
        if (q.size() != 0) held = q[0].d;
    endtask

    task automatic check_all();
        bit v;
        v = q.size() != 0;
        chk("a_valid", a_out_valid, v);
        chk("b_valid", b_out_valid, v);
        chk("a_in_ready", a_in_ready, q.size() < 2);
        chk("b_in_ready", b_in_ready, q.size() < 2);
        chk("a_occ", a_occ, q.size());
        chk("b_occ", b_occ, q.size());
        chk("a_ctrl", a_out_ctrl, v ? q[0].c : 8'h0);
        chk("b_ctrl", b_out_ctrl, v ? q[0].c : 8'h0);
        chk("a_data", a_out_data, v ? q[0].d : 32'h0);
        chk("b_data", b_out_data, v ? q[0].d : held);
        chk("a_stall", a_stall, scnt > 65535 ? 65535 : scnt);
        chk("b_stall", b_stall, scnt > 15 ? 15 : scnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_clk();
        @(negedge clk);
        check_all();
    endtask

    task automatic push(input logic [7:0] c, input logic [31:0] d, input logic rdy);
        in_valid = 1; in_ctrl = c; in_data = d; out_ready = rdy;
        step();
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; flush = 0; out_ready = 0;
        step();
        rst = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check_all();
        chk("reset_ready", a_in_ready, 1'b1);

        // streaming at one entry per cycle
        for (int i = 1; i <= 5; i++) begin
            push(8'(i), 32'(i * 16), 1'b1);
            chk("stream_ctrl", a_out_ctrl, 64'(i));
            chk("stream_occ", a_occ, 2'd1);
        end
        in_valid = 0;
        step();

        // backpressure then drain in order
        do_reset();
        push(8'h11, 32'hA, 1'b0);
        push(8'h22, 32'hB, 1'b0);
        push(8'h44, 32'hC, 1'b0);
        chk("bp_occ", a_occ, 2'd2);
        chk("bp_ready", a_in_ready, 1'b0);
        chk("bp_head", a_out_ctrl, 8'h11);
        chk("bp_stall", a_stall, 16'd2);
        push(8'h44, 32'hC, 1'b1);
        chk("drain_b", a_out_ctrl, 8'h22);
        push(8'h44, 32'hC, 1'b1);
        chk("drain_c", a_out_ctrl, 8'h44);
        in_valid = 0;
        step();
        chk("drain_empty", a_out_valid, 1'b0);
        chk("drain_stall", a_stall, 16'd2);

        // flush while full, with an incoming entry that must be dropped
        push(8'h55, 32'hDEADBEEF, 1'b0);
        push(8'h66, 32'h12345678, 1'b0);
        flush = 1; in_ctrl = 8'h33; in_data = 32'h33;
        step();
        flush = 0;
        chk("flush_valid", a_out_valid, 1'b0);
        chk("flush_ctrl", a_out_ctrl, 8'h0);
        chk("flush_data_clr", a_out_data, 32'h0);
        chk("flush_data_hold", b_out_data, 32'hDEADBEEF);
        chk("flush_b_ctrl", b_out_ctrl, 8'h0);
        in_valid = 0;
        step();
        chk("flush_no_33", a_out_valid, 1'b0);

        // asynchronous reset while two entries are held
        push(8'h71, 32'h1, 1'b0);
        push(8'h72, 32'h2, 1'b0);
        in_valid = 0;
        #2 rst = 1;
        #1;
        chk("arst_valid", a_out_valid, 1'b0);
        chk("arst_ctrl", a_out_ctrl, 8'h0);
        chk("arst_occ", a_occ, 2'd0);
        chk("arst_ready", a_in_ready, 1'b1);
        chk("arst_data", b_out_data, 32'h0);
        model_reset();
        step();
        rst = 0;

        // stall counter saturation in the narrow instance
        push(8'h99, 32'h9, 1'b0);
        in_valid = 0;
        repeat (20) step();
        chk("sat_b", b_stall, 4'd15);
        chk("sat_a", a_stall, 16'd20);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid  = $urandom_range(99) < 70;
            out_ready = $urandom_range(99) < 60;
            flush     = $urandom_range(99) < 5;
            in_ctrl   = 8'($urandom);
            in_data   = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
